bit_timer_ctrl: RTL and testbench
=================================

Name: bit_timer_ctrl

Overview:
Sequencing controller that drives two flex_counter instances to time a serial frame. The divider counter produces a one-cycle shift strobe every bit_period clocks. The bit counter counts strobes and ends the frame after frame_bits strobes. It sits between a serial shift register (consumer of shift_strobe) and the packet-level control FSM (issues start/abort, consumes frame_done).

Parameters:
NUM_CNT_BITS, 4, width of both counters, bit_period, frame_bits and bit_index

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  request to begin a frame; honoured only in IDLE
abort  input  1  cancel the current frame; honoured in RUN
bit_period  input  NUM_CNT_BITS  clocks per bit; latched on accepted start
frame_bits  input  NUM_CNT_BITS  bits per frame; latched on accepted start
busy  output  1  high in RUN and DONE
shift_strobe  output  1  one-cycle pulse per bit period
bit_index  output  NUM_CNT_BITS  strobes issued so far in current frame
frame_done  output  1  one-cycle pulse after the last strobe
cfg_err  output  1  one-cycle pulse when start is given with a zero config

Behaviour:
- Reset (n_rst=0, any time, including mid-frame):
  - state goes to IDLE; both counters and latched config go to 0.
  - busy, shift_strobe, bit_index, frame_done and cfg_err are all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - counters are held cleared.
  - start=1 with bit_period!=0 and frame_bits!=0: latch both values, go to RUN next cycle.
  - start=1 with either value 0: stay in IDLE; cfg_err=1 the next cycle for exactly one cycle.
  - abort is ignored.
- RUN:
  - divider count_enable=1, rollover_val = latched bit_period.
  - flex_counter semantics apply: count runs 1..rollover_val; rollover_flag is high while count==rollover_val; the next enabled edge wraps to 1.
  - shift_strobe = (state==RUN) && divider rollover_flag, so the first strobe comes P cycles after RUN entry, then one every P cycles.
  - bit counter count_enable = shift_strobe; bit_index = bit counter count_out.
  - last strobe is shift_strobe && (bit_index+1 == latched frame_bits), compared at NUM_CNT_BITS+1 bits; on it, go to DONE.
- DONE (exactly one cycle):
  - frame_done=1; clear=1 to both counters; go to IDLE.
  - start is ignored in DONE, so back-to-back frames need start in the following IDLE cycle.
- abort in RUN: clear both counters, go to IDLE next cycle, no frame_done.
- abort coincident with the last strobe: abort wins; shift_strobe still pulses that cycle, but there is no DONE.
- start in RUN or DONE: ignored.
- Changes to bit_period or frame_bits during a frame: no effect, since the latched copies are used.
- Latency (start high in IDLE cycle 0):
  - RUN from cycle 1.
  - strobes at cycles k*P+1 for k=1..F.
  - frame_done at cycle F*P+2; busy low from cycle F*P+3.
- Max values: P=F=2^NUM_CNT_BITS-1 must work (15 for the default); the +1 compare must not overflow.

Decomposition:
- Shared package timer_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t;
  - localparam default NUM_CNT_BITS.
- Sub-module: existing flex_counter, two instances (div_cnt, bit_cnt) with NUM_CNT_BITS passed through.
- This block contains only the FSM, the config latches and the glue logic.

Test Plan:
1. Normal frame: P=4, F=3, start pulse in cycle 0 -> shift_strobe at cycles 5, 9, 13; bit_index 0→1→2→3; frame_done only at cycle 14; busy high cycles 1–14.
2. Zero config: start with P=0, F=5 -> stays IDLE, cfg_err one pulse next cycle, busy=0, no strobes; repeat with P=3, F=0 -> same response.
3. Abort: P=3, F=4, abort after second strobe -> IDLE next cycle, bit_index=0, no frame_done; an immediate new start (P=2, F=1) -> strobe 2 cycles after RUN entry, then frame_done.
4. Edge values: P=15, F=15 -> 15 strobes spaced 15 cycles apart, bit_index reaches 15, frame_done at cycle 227; config inputs toggled mid-frame have no effect.
5. Reset mid-frame: n_rst low during RUN with bit_index=2 -> all outputs 0 immediately (asynchronously); after release stays IDLE until the next start.
6. Corner: abort on the last-strobe cycle -> strobe pulses, no frame_done; start held high in RUN/DONE -> ignored, with exactly one frame per accepted start.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and defaults for the serial bit timer controller and its counters.
// Combinational content only; no latency or flow control.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  localparam int DEFAULT_NUM_CNT_BITS = 4;

endpackage

// File: rtl/flex_counter.sv
// Programmable-rollover counter: counts 1..rollover_val while enabled, flag high at rollover_val.
// One-cycle registered update; clear has priority over count_enable, no backpressure.
module flex_counter
  import timer_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEFAULT_NUM_CNT_BITS
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic [NUM_CNT_BITS-1:0] w_next_count;
  logic                    r_flag;
  logic                    w_next_flag;

  always_comb begin
    w_next_count = r_count;
    w_next_flag  = r_flag;
    if (clear) begin
      w_next_count = '0;
      w_next_flag  = 1'b0;
    end else if (count_enable) begin
      w_next_count = (r_count == rollover_val) ? CNT_ONE : r_count + CNT_ONE;
      w_next_flag  = (w_next_count == rollover_val);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_flag  <= w_next_flag;
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = r_flag;

endmodule

// File: rtl/bit_timer_ctrl.sv
// Frame timer: divider strobes every bit_period clocks, bit counter ends frame after frame_bits strobes.
// First strobe P cycles after RUN entry, frame_done one cycle after last strobe; start only taken in IDLE.
module bit_timer_ctrl
  import timer_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEFAULT_NUM_CNT_BITS
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CNT_BITS-1:0] bit_period,
  input  logic [NUM_CNT_BITS-1:0] frame_bits,
  output logic                    busy,
  output logic                    shift_strobe,
  output logic [NUM_CNT_BITS-1:0] bit_index,
  output logic                    frame_done,
  output logic                    cfg_err
);

  timer_state_t            r_state;
  logic [NUM_CNT_BITS-1:0] r_bit_period;
  logic [NUM_CNT_BITS-1:0] r_frame_bits;
  logic                    r_busy;
  logic                    r_frame_done;
  logic                    r_cfg_err;

  logic                    w_run;
  logic                    w_clear;
  logic                    w_cfg_ok;
  logic                    w_div_flag;
  logic [NUM_CNT_BITS-1:0] w_div_count;
  logic [NUM_CNT_BITS-1:0] w_bit_idx;
  logic                    w_bit_flag;
  logic                    w_shift_strobe;
  logic                    w_last_strobe;
  logic                    w_unused_cnt;

  assign w_run          = (r_state == RUN);
  assign w_clear        = !w_run || abort;
  assign w_cfg_ok       = (bit_period != '0) && (frame_bits != '0);
  assign w_shift_strobe = w_run && w_div_flag;
  // Extra bit keeps bit_index+1 from wrapping when frame_bits is all ones.
  assign w_last_strobe  = w_shift_strobe &&
                          (({1'b0, w_bit_idx} + {{NUM_CNT_BITS{1'b0}}, 1'b1}) == {1'b0, r_frame_bits});
  assign w_unused_cnt   = &{1'b0, w_div_count, w_bit_flag};

  flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) div_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_clear),
    .count_enable (w_run),
    .rollover_val (r_bit_period),
    .count_out    (w_div_count),
    .rollover_flag(w_div_flag)
  );

  flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_clear),
    .count_enable (w_shift_strobe),
    .rollover_val (r_frame_bits),
    .count_out    (w_bit_idx),
    .rollover_flag(w_bit_flag)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_bit_period <= '0;
      r_frame_bits <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_bit_period <= bit_period;
              r_frame_bits <= frame_bits;
              r_state      <= RUN;
              r_busy       <= 1'b1;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort beats a coincident last strobe: no DONE cycle in that case.
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_last_strobe) begin
            r_state      <= DONE;
            r_frame_done <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign shift_strobe = w_shift_strobe;
  assign bit_index    = w_bit_idx;
  assign frame_done   = r_frame_done;
  assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_bit_timer_ctrl.sv
// Bench for bit_timer_ctrl: directed scenarios plus random start/abort/config traffic,
// checked every cycle against a frame-schedule reference model.
module tb_bit_timer_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic         abort;
  logic [W-1:0] bit_period;
  logic [W-1:0] frame_bits;
  logic         busy;
  logic         shift_strobe;
  logic [W-1:0] bit_index;
  logic         frame_done;
  logic         cfg_err;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: an accepted frame is described only by its start cycle and config.
  int cyc;
  bit m_in_frame;
  int m_s, m_p, m_f;
  int m_err_cyc;

  int obs_str, obs_done, last_done_cyc, max_idx;

  always #5 clk = ~clk;

  bit_timer_ctrl #(.NUM_CNT_BITS(W)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .abort       (abort),
    .bit_period  (bit_period),
    .frame_bits  (frame_bits),
    .busy        (busy),
    .shift_strobe(shift_strobe),
    .bit_index   (bit_index),
    .frame_done  (frame_done),
    .cfg_err     (cfg_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    int   rel;
    int   e_idx;
    logic e_busy, e_str, e_done, e_err;
    e_busy = 1'b0;
    e_str  = 1'b0;
    e_done = 1'b0;
    e_idx  = 0;
    e_err  = (cyc == m_err_cyc);
    if (m_in_frame) begin
      rel    = cyc - m_s;
      e_busy = 1'b1;
      e_done = (rel == m_f * m_p + 2);
      e_str  = !e_done && (rel >= 2) && ((rel - 1) % m_p == 0);
      if (rel >= 2) e_idx = (rel - 2) / m_p;
    end
    check_val("busy", 32'(busy), 32'(e_busy));
    check_val("shift_strobe", 32'(shift_strobe), 32'(e_str));
    check_val("bit_index", 32'(bit_index), 32'(e_idx));
    check_val("frame_done", 32'(frame_done), 32'(e_done));
    check_val("cfg_err", 32'(cfg_err), 32'(e_err));
    obs_str  += int'(shift_strobe);
    obs_done += int'(frame_done);
    if (frame_done === 1'b1) last_done_cyc = cyc;
    if (int'(bit_index) > max_idx) max_idx = int'(bit_index);
  endtask

  // One clock cycle: check outputs, apply inputs, advance the model.
  task automatic step(input logic st, input logic ab, input logic [W-1:0] p, input logic [W-1:0] f);
    int rel;
    check_outputs();
    start      = st;
    abort      = ab;
    bit_period = p;
    frame_bits = f;
    if (!m_in_frame) begin
      if (st) begin
        if (p != 0 && f != 0) begin
          m_in_frame = 1'b1;
          m_s = cyc;
          m_p = int'(p);
          m_f = int'(f);
        end else begin
          m_err_cyc = cyc + 1;
        end
      end
    end else begin
      rel = cyc - m_s;
      if (rel == m_f * m_p + 2) m_in_frame = 1'b0;
      else if (ab) m_in_frame = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic st, input logic ab, input logic [W-1:0] p, input logic [W-1:0] f);
    for (int i = 0; i < n; i++) step(st, ab, p, f);
  endtask

  task automatic clr_obs();
    obs_str = 0;
    obs_done = 0;
    last_done_cyc = -1;
    max_idx = 0;
  endtask

  task automatic async_reset();
    start = 1'b0;
    abort = 1'b0;
    #1 n_rst = 1'b0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_strobe", 32'(shift_strobe), 32'd0);
    check_val("rst_bit_index", 32'(bit_index), 32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_cfg_err", 32'(cfg_err), 32'd0);
    #2 n_rst = 1'b1;
    @(posedge clk);
    #1;
    m_in_frame = 1'b0;
    m_err_cyc  = -1;
    cyc++;
  endtask

  initial begin
    int s0;
    logic [W-1:0] rp, rf;
    n_rst      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    bit_period = '0;
    frame_bits = '0;
    cyc        = 0;
    m_in_frame = 1'b0;
    m_err_cyc  = -1;
    clr_obs();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_bit_index", 32'(bit_index), 32'd0);
    check_val("reset_cfg_err", 32'(cfg_err), 32'd0);
    n_rst = 1'b1;

    // Normal frame P=4, F=3.
    clr_obs();
    step(1'b1, 1'b0, 4'd4, 4'd3);
    run(15, 1'b0, 1'b0, 4'd4, 4'd3);
    check_val("t1_strobes", 32'(obs_str), 32'd3);
    check_val("t1_done_count", 32'(obs_done), 32'd1);
    check_val("t1_max_index", 32'(max_idx), 32'd3);

    // Zero configurations.
    clr_obs();
    step(1'b1, 1'b0, 4'd0, 4'd5);
    run(3, 1'b0, 1'b0, 4'd0, 4'd5);
    step(1'b1, 1'b0, 4'd3, 4'd0);
    run(3, 1'b0, 1'b0, 4'd3, 4'd0);
    check_val("t2_strobes", 32'(obs_str), 32'd0);

    // Abort after second strobe, then immediate new frame.
    clr_obs();
    step(1'b1, 1'b0, 4'd3, 4'd4);
    run(7, 1'b0, 1'b0, 4'd3, 4'd4);
    step(1'b0, 1'b1, 4'd3, 4'd4);
    step(1'b1, 1'b0, 4'd2, 4'd1);
    run(6, 1'b0, 1'b0, 4'd2, 4'd1);
    check_val("t3_strobes", 32'(obs_str), 32'd3);
    check_val("t3_done_count", 32'(obs_done), 32'd1);

    // Maximum values with config inputs churning mid-frame.
    clr_obs();
    s0 = cyc;
    step(1'b1, 1'b0, 4'd15, 4'd15);
    for (int i = 0; i < 230; i++) step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    check_val("t4_strobes", 32'(obs_str), 32'd15);
    check_val("t4_max_index", 32'(max_idx), 32'd15);
    check_val("t4_done_at", 32'(last_done_cyc - s0), 32'd227);

    // Asynchronous reset mid-frame with bit_index at 2.
    step(1'b1, 1'b0, 4'd3, 4'd4);
    run(7, 1'b0, 1'b0, 4'd3, 4'd4);
    check_val("t5_pre_index", 32'(bit_index), 32'd2);
    async_reset();
    clr_obs();
    run(6, 1'b0, 1'b0, 4'd3, 4'd4);
    check_val("t5_idle_strobes", 32'(obs_str), 32'd0);

    // Abort on the last strobe.
    clr_obs();
    step(1'b1, 1'b0, 4'd2, 4'd2);
    run(4, 1'b0, 1'b0, 4'd2, 4'd2);
    step(1'b0, 1'b1, 4'd2, 4'd2);
    run(4, 1'b0, 1'b0, 4'd2, 4'd2);
    check_val("t6_abort_strobes", 32'(obs_str), 32'd2);
    check_val("t6_abort_done", 32'(obs_done), 32'd0);

    // Start held through RUN and DONE gives one frame.
    clr_obs();
    run(7, 1'b1, 1'b0, 4'd2, 4'd2);
    run(4, 1'b0, 1'b0, 4'd2, 4'd2);
    check_val("t6_held_done", 32'(obs_done), 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rp = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      rf = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 29) == 0), rp, rf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
